// File: rtl/scr1_imem_opc_monitor.sv
// IMEM response opcode monitor: matched {pc, instr} fetches are queued in a small FIFO for a trace reader.
// Optional per-entry cycle timestamp when SCR1_OPCMON_TIMESTAMP_EN is defined (rd_ts port present only then).
module scr1_imem_opc_monitor #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               imem_resp,
    input  logic [31:0]              imem_rdata,
    input  logic [31:0]              curr_pc,
    input  logic                     cfg_en,
    input  logic [6:0]               cfg_opcode,
    input  logic [2:0]               cfg_funct3,
    input  logic                     cfg_f3_chk,
    input  logic                     clr,
    input  logic                     rd_req,
    output logic                     rd_vld,
    output logic [31:0]              rd_pc,
    output logic [31:0]              rd_instr,
`ifdef SCR1_OPCMON_TIMESTAMP_EN
    output logic [31:0]              rd_ts,
`endif
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         match_cnt,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [31:0]      r_pc_mem    [DEPTH];
    logic [31:0]      r_instr_mem [DEPTH];

    logic w_match;
    logic w_full;
    logic w_vld;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_match = cfg_en & (imem_resp == 2'b01) & (imem_rdata[6:0] == cfg_opcode)
                   & (~cfg_f3_chk | (imem_rdata[14:12] == cfg_funct3));
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_vld   = (r_level != '0);
    assign w_pop   = rd_req & w_vld;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push  = w_match & (~w_full | w_pop);
    assign w_drop  = w_match & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (w_push && !clr) begin
            r_pc_mem[r_wptr]    <= curr_pc;
            r_instr_mem[r_wptr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_match && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
            if (w_drop)                    r_ovf <= 1'b1;
        end
    end

`ifdef SCR1_OPCMON_TIMESTAMP_EN
    logic [31:0] r_ts_cnt;
    logic [31:0] r_ts_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_ts_mem[i] <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 32'd1;
            if (w_push && !clr) r_ts_mem[r_wptr] <= r_ts_cnt;
        end
    end

    assign rd_ts = w_vld ? r_ts_mem[r_rptr] : '0;
`endif

    assign rd_vld    = w_vld;
    assign rd_pc     = w_vld ? r_pc_mem[r_rptr]    : '0;
    assign rd_instr  = w_vld ? r_instr_mem[r_rptr] : '0;
    assign level     = r_level;
    assign match_cnt = r_cnt;
    assign ovf       = r_ovf;

endmodule
